// File: rtl/uart_cmd_parser_if.sv
// Purpose: byte-level link between the parser and the UART rx/tx blocks.
// Latency: none, wires only.
// Backpressure: tx_busy from the transmitter holds off tx_start.
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;

    // Parser side
    modport master (
        input  rx_data, rx_done, tx_busy,
        output tx_data, tx_start
    );

    // UART side (receiver + transmitter)
    modport slave (
        output rx_data, rx_done, tx_busy,
        input  tx_data, tx_start
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Purpose: decode ASCII command bytes into control pulses, a mode level and ACK/NAK replies.
// Latency: pulses, mode and queued reply appear 1 cycle after rx_done; tx_start follows once tx_busy is low.
// Backpressure: one-deep reply register, newest reply overwrites an unsent one; tx_start gated by live tx_busy.
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CYC = 100_000_000,
    parameter int unsigned RST_HOLD    = 4,
    parameter logic [7:0]  ACK_CHAR    = 8'h4B,
    parameter logic [7:0]  NAK_CHAR    = 8'h3F
) (
    input  logic              clk,
    input  logic              reset,
    uart_cmd_parser_if.master uart,
    output logic              cmd_run_stop,
    output logic              cmd_clear,
    output logic              cmd_sr_start,
    output logic              cmd_dht_start,
    output logic              cmd_up,
    output logic              cmd_down,
    output logic              cmd_reset,
    output logic              sensor_mode,
    output logic [7:0]        err_cnt
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, WAIT_ARG} state_t;

    // Pulse vector bit order: run_stop, clear, sr_start, dht_start, up, down
    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [5:0]    pulse_q, pulse_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          mode_q, mode_d;
    logic          pend_q, pend_d;
    logic [7:0]    txd_q, txd_d;
    logic [7:0]    err_q, err_d;

    logic [7:0]    byte_lc;
    logic          q_ack;
    logic          q_nak;
    logic          start;

    // Next-state: command decode, argument wait with timeout, reset hold and reply queue
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pulse_d = '0;
        hold_d  = hold_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        txd_d   = txd_q;
        err_d   = err_q;
        q_ack   = 1'b0;
        q_nak   = 1'b0;
        byte_lc = uart.rx_data;
        // Live tx_busy gates the start so it can never fire into a busy transmitter
        start   = pend_q && !uart.tx_busy;

        if (uart.rx_data >= 8'h41 && uart.rx_data <= 8'h5A) begin
            byte_lc = uart.rx_data | 8'h20;
        end

        if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end

        case (state_q)
            IDLE: begin
                if (uart.rx_done) begin
                    case (byte_lc)
                        8'h72: begin pulse_d = 6'b100000; q_ack = 1'b1; end // 'r'
                        8'h63: begin pulse_d = 6'b010000; q_ack = 1'b1; end // 'c'
                        8'h75: begin pulse_d = 6'b001000; q_ack = 1'b1; end // 'u'
                        8'h74: begin pulse_d = 6'b000100; q_ack = 1'b1; end // 't'
                        8'h2B: begin pulse_d = 6'b000010; q_ack = 1'b1; end // '+'
                        8'h2D: begin pulse_d = 6'b000001; q_ack = 1'b1; end // '-'
                        8'h78: begin hold_d = HW'(RST_HOLD); q_ack = 1'b1; end // 'x' restarts hold
                        8'h6D: begin state_d = WAIT_ARG; tmo_d = '0; end       // 'm' waits for arg
                        8'h0D, 8'h0A: ;                                        // CR/LF silently dropped
                        default: q_nak = 1'b1;
                    endcase
                end
            end
            WAIT_ARG: begin
                // A received byte beats the timeout when both land on the same cycle
                if (uart.rx_done) begin
                    state_d = IDLE;
                    if (uart.rx_data == 8'h30 || uart.rx_data == 8'h31) begin
                        mode_d = uart.rx_data[0];
                        q_ack  = 1'b1;
                    end else begin
                        q_nak = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    q_nak   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A reply queued on the start cycle stays pending for the next send
        if (start) begin
            pend_d = 1'b0;
        end
        if (q_ack || q_nak) begin
            pend_d = 1'b1;
            txd_d  = q_ack ? ACK_CHAR : NAK_CHAR;
        end
        if (q_nak && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            pulse_q <= '0;
            hold_q  <= '0;
            mode_q  <= 1'b0;
            pend_q  <= 1'b0;
            txd_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            pulse_q <= pulse_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            txd_q   <= txd_d;
            err_q   <= err_d;
        end
    end

    assign cmd_run_stop  = pulse_q[5];
    assign cmd_clear     = pulse_q[4];
    assign cmd_sr_start  = pulse_q[3];
    assign cmd_dht_start = pulse_q[2];
    assign cmd_up        = pulse_q[1];
    assign cmd_down      = pulse_q[0];
    assign cmd_reset     = (hold_q != '0);
    assign sensor_mode   = mode_q;
    assign err_cnt       = err_q;
    assign uart.tx_data  = txd_q;
    assign uart.tx_start = start;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Purpose: randomized and directed check of uart_cmd_parser against a cycle-level reference model.
// Latency: model predicts registered outputs one cycle after the inputs it consumes.
// Backpressure: tx_busy is toggled randomly to exercise the one-deep reply register.
module tb_uart_cmd_parser;
    localparam int TMO  = 20;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_run_stop, cmd_clear, cmd_sr_start, cmd_dht_start, cmd_up, cmd_down;
    logic       cmd_reset, sensor_mode;
    logic [7:0] err_cnt;

    uart_cmd_parser_if u_if ();

    uart_cmd_parser #(.TIMEOUT_CYC(TMO), .RST_HOLD(HOLD), .ACK_CHAR(8'h4B), .NAK_CHAR(8'h3F)) dut (
        .clk(clk), .reset(reset), .uart(u_if),
        .cmd_run_stop(cmd_run_stop), .cmd_clear(cmd_clear), .cmd_sr_start(cmd_sr_start),
        .cmd_dht_start(cmd_dht_start), .cmd_up(cmd_up), .cmd_down(cmd_down),
        .cmd_reset(cmd_reset), .sensor_mode(sensor_mode), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] pulses();
        return {cmd_run_stop, cmd_clear, cmd_sr_start, cmd_dht_start, cmd_up, cmd_down};
    endfunction

    // Reference model: what each output must hold after every clock edge
    longint     cyc = 0;
    logic [5:0] m_pulse = '0;
    int         m_hold = 0;
    bit         m_mode = 0;
    bit         m_wait = 0;
    longint     m_deadline = 0;
    bit         m_pend = 0;
    logic [7:0] m_txd = '0;
    int         m_err = 0;

    always @(posedge clk) begin
        logic [7:0] b;
        bit qa, qn, fire;
        cyc++;
        qa = 0; qn = 0;
        if (reset) begin
            m_pulse = '0; m_hold = 0; m_mode = 0; m_wait = 0;
            m_pend = 0; m_txd = '0; m_err = 0;
        end else begin
            fire = m_pend && !u_if.tx_busy;
            m_pulse = '0;
            if (m_hold > 0) m_hold--;
            b = u_if.rx_data;
            if (b >= "A" && b <= "Z") b = b + 8'd32;
            if (u_if.rx_done) begin
                if (m_wait) begin
                    m_wait = 0;
                    if (u_if.rx_data == "0" || u_if.rx_data == "1") begin
                        m_mode = u_if.rx_data[0];
                        qa = 1;
                    end else qn = 1;
                end else begin
                    case (b)
                        "r": begin m_pulse = 6'b100000; qa = 1; end
                        "c": begin m_pulse = 6'b010000; qa = 1; end
                        "u": begin m_pulse = 6'b001000; qa = 1; end
                        "t": begin m_pulse = 6'b000100; qa = 1; end
                        "+": begin m_pulse = 6'b000010; qa = 1; end
                        "-": begin m_pulse = 6'b000001; qa = 1; end
                        "x": begin m_hold = HOLD; qa = 1; end
                        "m": begin m_wait = 1; m_deadline = cyc + TMO; end
                        8'h0D, 8'h0A: ;
                        default: qn = 1;
                    endcase
                end
            end else if (m_wait && cyc == m_deadline) begin
                m_wait = 0;
                qn = 1;
            end
            if (fire) m_pend = 0;
            if (qa || qn) begin
                m_pend = 1;
                m_txd = qa ? 8'h4B : 8'h3F;
            end
            if (qn && m_err < 255) m_err++;
        end
    end

    // Every-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("pulses", int'(pulses()), int'(m_pulse));
            check("cmd_reset", int'(cmd_reset), int'(m_hold > 0));
            check("sensor_mode", int'(sensor_mode), int'(m_mode));
            check("tx_start", int'(u_if.tx_start), int'(m_pend && !u_if.tx_busy));
            check("tx_data", int'(u_if.tx_data), int'(m_txd));
            check("err_cnt", int'(err_cnt), m_err);
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        u_if.rx_data = b;
        u_if.rx_done = 1'b1;
        @(posedge clk); #1;
        u_if.rx_done = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [7:0] cmd_chars [6] = '{"r", "C", "u", "T", "+", "-"};
    logic [5:0] cmd_vecs  [6] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001};
    logic [7:0] rnd_tbl  [18] = '{"r", "R", "c", "C", "u", "U", "t", "T", "+", "-", "x", "m",
                                  "M", "0", "1", 8'h0D, 8'h0A, "q"};

    initial begin
        int cnt;
        u_if.rx_data = '0;
        u_if.rx_done = 1'b0;
        u_if.tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset values
        check("rst_pulses", int'(pulses()), 0);
        check("rst_tx", int'({u_if.tx_start, u_if.tx_data}), 0);
        check("rst_levels", int'({cmd_reset, sensor_mode, err_cnt}), 0);

        // NAK bookkeeping: 'z' and bad argument 'q' NAK, CR is silent
        send("z");
        check("nak_z_data", int'(u_if.tx_data), 8'h3F);
        send("M");
        send("q");
        check("q_no_pulse", int'(pulses()), 0);
        send(8'h0D);
        @(posedge clk); #1;
        check("cr_no_start", int'(u_if.tx_start), 0);
        check("err_two", int'(err_cnt), 2);

        // Each command: one-hot pulse plus immediate ACK
        for (int i = 0; i < 6; i++) begin
            send(cmd_chars[i]);
            check("cmd_pulse", int'(pulses()), int'(cmd_vecs[i]));
            check("cmd_ack", int'({u_if.tx_start, u_if.tx_data}), 9'h14B);
            @(posedge clk); #1;
            check("cmd_pulse_off", int'(pulses()), 0);
        end

        // Mode argument within the timeout window
        send("M");
        repeat (8) @(posedge clk);
        send("1");
        check("mode_set", int'(sensor_mode), 1);
        check("mode_ack", int'({u_if.tx_start, u_if.tx_data}), 9'h14B);
        send("m");
        send("0");
        check("mode_clr", int'(sensor_mode), 0);

        // Timeout: NAK exactly TMO cycles after 'M'
        send("M");
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo_early", int'(u_if.tx_start), 0);
        @(posedge clk); #1;
        check("tmo_nak", int'({u_if.tx_start, u_if.tx_data}), 9'h13F);
        check("tmo_mode", int'(sensor_mode), 0);
        send("r");
        check("tmo_then_r", int'(cmd_run_stop), 1);

        // Busy transmitter: two commands, one deferred start
        u_if.tx_busy = 1'b1;
        send("r");
        check("busy_r", int'(cmd_run_stop), 1);
        send("c");
        check("busy_c", int'(cmd_clear), 1);
        cnt = 0;
        repeat (4) begin @(negedge clk); if (u_if.tx_start) cnt++; end
        check("busy_hold", cnt, 0);
        @(posedge clk); #1;
        u_if.tx_busy = 1'b0;
        cnt = 0;
        repeat (5) begin @(negedge clk); if (u_if.tx_start) cnt++; end
        check("busy_one_start", cnt, 1);
        check("busy_data", int'(u_if.tx_data), 8'h4B);

        // Reset hold restarted by a second 'x'
        do_reset();
        cnt = 0;
        fork
            begin repeat (14) begin @(negedge clk); if (cmd_reset) cnt++; end end
            begin send("x"); send("x"); end
        join
        check("hold_len", cnt, 6);

        // Reset mid argument wait: everything back to zero, no late NAK
        send("M");
        send("1");
        send("M");
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out", int'({pulses(), cmd_reset, sensor_mode, u_if.tx_start, u_if.tx_data, err_cnt}), 0);
        reset = 1'b0;
        cnt = 0;
        repeat (TMO + 5) begin @(negedge clk); if (u_if.tx_start) cnt++; end
        check("mid_rst_quiet", cnt + int'(err_cnt), 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            u_if.rx_done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) u_if.rx_data = 8'($urandom);
            else u_if.rx_data = rnd_tbl[$urandom_range(0, 17)];
            if ($urandom_range(0, 5) == 0) u_if.tx_busy = ~u_if.tx_busy;
            reset = (i == 3500);
        end
        @(posedge clk); #1;
        u_if.rx_done = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
